// File: rtl/mux_rr_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler.
//   state_e       : FSM encoding (StIdle = 0, StGrant = 1)
//   DefMaxBurst   : default beat limit per grant
package mux_rr_sched_pkg;

   typedef enum logic {
      StIdle  = 1'b0,
      StGrant = 1'b1
   } state_e;

   localparam int unsigned DefMaxBurst = 4;

endpackage

// File: rtl/mux_rr_sched_if.sv
// Handshake bundle between the scheduler, its requesters and the downstream mux.
//   req, last, dout_rdy : requester / downstream side -> scheduler
//   sel, sel_v, gnt     : scheduler -> mux select and requesters
//   beat                : scheduler -> transfer qualifier for this cycle
// master = scheduler side, slave = environment side.
interface mux_rr_sched_if #(
   parameter int unsigned NUMIN  = 16,
   parameter int unsigned SWIDTH = $clog2(NUMIN)
);
   logic [NUMIN-1:0]  req;
   logic [NUMIN-1:0]  last;
   logic              dout_rdy;
   logic [SWIDTH-1:0] sel;
   logic              sel_v;
   logic [NUMIN-1:0]  gnt;
   logic              beat;

   modport master (
      input  req, last, dout_rdy,
      output sel, sel_v, gnt, beat
   );

   modport slave (
      output req, last, dout_rdy,
      input  sel, sel_v, gnt, beat
   );
endinterface

// File: rtl/mux_rr_sched_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index this round
//   win : first set request at or after ptr, wrapping NUMIN-1 -> 0
//   any : at least one request set
module rr_pick #(
   parameter int unsigned NUMIN  = 16,
   parameter int unsigned SWIDTH = $clog2(NUMIN)
) (
   input  logic [NUMIN-1:0]  req,
   input  logic [SWIDTH-1:0] ptr,
   output logic [SWIDTH-1:0] win,
   output logic              any
);
   localparam logic [SWIDTH:0] NumInW = (SWIDTH+1)'(NUMIN);

   logic [NUMIN-1:0]  rot;
   logic [SWIDTH-1:0] off;
   logic [SWIDTH:0]   sum;

   always_comb begin
      // Doubled vector shifted by ptr puts req[ptr] at bit 0 without a modulo.
      rot = NUMIN'({req, req} >> ptr);
      off = '0;
      for (int i = NUMIN - 1; i >= 0; i--) begin
         if (rot[i]) off = SWIDTH'(i);
      end
      // Explicit wrap keeps non-power-of-2 NUMIN correct.
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= NumInW) sum = sum - NumInW;
      win = sum[SWIDTH-1:0];
   end

   assign any = |req;

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler for an NUMIN-input mux. Grants one requester, holds the
// select for a burst, and releases on last, on the MAXBURST beat limit or on
// request withdrawal. Each grant is followed by one idle cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : req/last/dout_rdy in, sel/sel_v/gnt/beat out (see mux_rr_sched_if)
module mux_rr_sched
   import mux_rr_sched_pkg::*;
#(
   parameter int unsigned NUMIN    = 16,
   parameter int unsigned SWIDTH   = $clog2(NUMIN),
   parameter int unsigned MAXBURST = DefMaxBurst,
   parameter int unsigned BWIDTH   = 8
) (
   input  logic          clk,
   input  logic          rst,
   mux_rr_sched_if.master bus
);
   localparam logic [BWIDTH-1:0] CntLast = (MAXBURST == 0) ? '0 : BWIDTH'(MAXBURST - 1);
   localparam logic [SWIDTH-1:0] SelMax  = SWIDTH'(NUMIN - 1);

   state_e            state_q, state_d;
   logic [SWIDTH-1:0] sel_q, sel_d;
   logic              sel_v_q, sel_v_d;
   logic [NUMIN-1:0]  gnt_q, gnt_d;
   logic [SWIDTH-1:0] ptr_q, ptr_d;
   logic [BWIDTH-1:0] cnt_q, cnt_d;

   logic [SWIDTH-1:0] win;
   logic              any;
   logic              beat;
   logic              limit_hit;
   logic              rel;

   rr_pick #(
      .NUMIN  (NUMIN),
      .SWIDTH (SWIDTH)
   ) u_pick (
      .req (bus.req),
      .ptr (ptr_q),
      .win (win),
      .any (any)
   );

   assign beat      = sel_v_q & bus.req[sel_q] & bus.dout_rdy;
   assign limit_hit = (MAXBURST != 0) && (cnt_q == CntLast);
   // All release causes fold into one signal so ptr steps once at most.
   assign rel       = (beat & bus.last[sel_q]) | (beat & limit_hit) | ~bus.req[sel_q];

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      sel_v_d = sel_v_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (any) begin
               state_d    = StGrant;
               sel_d      = win;
               sel_v_d    = 1'b1;
               gnt_d      = '0;
               gnt_d[win] = 1'b1;
               cnt_d      = '0;
            end
         end
         StGrant: begin
            if (rel) begin
               state_d = StIdle;
               sel_v_d = 1'b0;
               gnt_d   = '0;
               cnt_d   = '0;
               ptr_d   = (sel_q == SelMax) ? '0 : sel_q + 1'b1;
            end else if (beat && (cnt_q != '1)) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         sel_q   <= '0;
         sel_v_q <= 1'b0;
         gnt_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         sel_v_q <= sel_v_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.sel   = sel_q;
   assign bus.sel_v = sel_v_q;
   assign bus.gnt   = gnt_q;
   assign bus.beat  = beat;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed bench for mux_rr_sched: NUMIN=4 and NUMIN=5 instances, MAXBURST=3.
module tb_mux_rr_sched;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mux_rr_sched_if #(.NUMIN(4)) bus4 ();
   mux_rr_sched_if #(.NUMIN(5)) bus5 ();

   mux_rr_sched #(
      .NUMIN    (4),
      .MAXBURST (3)
   ) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.master)
   );

   mux_rr_sched #(
      .NUMIN    (5),
      .MAXBURST (3)
   ) u_dut5 (
      .clk (clk),
      .rst (rst),
      .bus (bus5.master)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled at negedge+1, away from the active edge.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Called on the first cycle of a grant; runs it to the idle cycle.
   task automatic burst(input string tag, input int exp_sel, input int exp_beats);
      int beats = 0;
      int cyc   = 0;
      check({tag, "_sel"}, 32'(bus4.sel), 32'(exp_sel));
      check({tag, "_gnt"}, 32'(bus4.gnt), 32'(1) << exp_sel);
      while (bus4.sel_v === 1'b1 && cyc < 40) begin
         if (bus4.beat === 1'b1) beats++;
         check({tag, "_onehot"}, 32'($countones(bus4.gnt)), 32'd1);
         tick();
         cyc++;
      end
      check({tag, "_beats"}, 32'(beats), 32'(exp_beats));
      check({tag, "_idle"}, 32'(bus4.sel_v), 32'd0);
      check({tag, "_gnt0"}, 32'(bus4.gnt), 32'd0);
   endtask

   initial begin
      bus4.req = '0; bus4.last = '0; bus4.dout_rdy = 1'b1;
      bus5.req = '0; bus5.last = '0; bus5.dout_rdy = 1'b1;
      tick();
      check("rst_sel", 32'(bus4.sel), 32'd0);
      check("rst_sel_v", 32'(bus4.sel_v), 32'd0);
      check("rst_gnt", 32'(bus4.gnt), 32'd0);
      check("rst_beat", 32'(bus4.beat), 32'd0);
      rst = 1'b0;

      // Single requester, last on 2nd beat, one idle cycle, re-grant.
      bus4.req = 4'b0100;
      #1;
      check("t2_pre_v", 32'(bus4.sel_v), 32'd0);
      tick();
      check("t2_v", 32'(bus4.sel_v), 32'd1);
      check("t2_sel", 32'(bus4.sel), 32'd2);
      check("t2_gnt", 32'(bus4.gnt), 32'h4);
      check("t2_b1", 32'(bus4.beat), 32'd1);
      tick();
      bus4.last = 4'b0100;
      #1;
      check("t2_b2", 32'(bus4.beat), 32'd1);
      check("t2_b2_v", 32'(bus4.sel_v), 32'd1);
      tick();
      bus4.last = 4'b0000;
      check("t2_idle", 32'(bus4.sel_v), 32'd0);
      check("t2_hold", 32'(bus4.sel), 32'd2);
      tick();
      check("t2_regnt_v", 32'(bus4.sel_v), 32'd1);
      check("t2_regnt", 32'(bus4.sel), 32'd2);

      // Reset mid-grant: immediate clear, ptr back to 0.
      rst = 1'b1;
      #1;
      check("t1_v", 32'(bus4.sel_v), 32'd0);
      check("t1_gnt", 32'(bus4.gnt), 32'd0);
      check("t1_sel", 32'(bus4.sel), 32'd0);
      tick();
      rst = 1'b0;
      bus4.req = 4'b1111;
      tick();
      check("t1_ptr0", 32'(bus4.sel), 32'd0);

      // All requesting, MAXBURST limits each grant.
      burst("t3a", 0, 3);
      tick(); burst("t3b", 1, 3);
      tick(); burst("t3c", 2, 3);
      tick(); burst("t3d", 3, 3);
      tick(); burst("t3e", 0, 3);

      // Backpressure mid-burst.
      bus4.req = 4'b0001;
      tick();
      check("t4_sel", 32'(bus4.sel), 32'd0);
      check("t4_b1", 32'(bus4.beat), 32'd1);
      tick();
      bus4.dout_rdy = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         check("t4_stall_beat", 32'(bus4.beat), 32'd0);
         check("t4_stall_v", 32'(bus4.sel_v), 32'd1);
         tick();
      end
      bus4.dout_rdy = 1'b1;
      #1;
      burst("t4", 0, 2);

      // Withdrawal of sel=3, ptr wraps to 0.
      bus4.req = 4'b1000;
      tick();
      check("t5_sel", 32'(bus4.sel), 32'd3);
      check("t5_b1", 32'(bus4.beat), 32'd1);
      tick();
      bus4.req = 4'b0011;
      #1;
      check("t5_wd_beat", 32'(bus4.beat), 32'd0);
      check("t5_wd_v", 32'(bus4.sel_v), 32'd1);
      tick();
      check("t5_idle", 32'(bus4.sel_v), 32'd0);
      check("t5_hold", 32'(bus4.sel), 32'd3);
      tick();
      check("t5_wrap_v", 32'(bus4.sel_v), 32'd1);
      check("t5_wrap", 32'(bus4.sel), 32'd0);
      bus4.req = 4'b0000;
      tick();
      check("t5_rel", 32'(bus4.sel_v), 32'd0);

      // last on the limit beat: one release, ptr=2.
      bus4.req = 4'b0010;
      tick();
      check("t6_sel", 32'(bus4.sel), 32'd1);
      tick();
      check("t6_b2", 32'(bus4.beat), 32'd1);
      tick();
      bus4.last = 4'b0010;
      #1;
      check("t6_b3", 32'(bus4.beat), 32'd1);
      tick();
      bus4.last = 4'b0000;
      bus4.req  = 4'b1111;
      check("t6_idle", 32'(bus4.sel_v), 32'd0);
      tick();
      check("t6_next", 32'(bus4.sel), 32'd2);
      bus4.req = 4'b0000;

      // NUMIN=5: simultaneous release on sel=4 wraps to 0.
      bus5.req = 5'b10000;
      tick();
      check("t6n5_sel", 32'(bus5.sel), 32'd4);
      check("t6n5_gnt", 32'(bus5.gnt), 32'h10);
      tick();
      tick();
      bus5.last = 5'b10000;
      #1;
      check("t6n5_b3", 32'(bus5.beat), 32'd1);
      tick();
      bus5.last = 5'b00000;
      bus5.req  = 5'b11111;
      check("t6n5_idle", 32'(bus5.sel_v), 32'd0);
      check("t6n5_hold", 32'(bus5.sel), 32'd4);
      tick();
      check("t6n5_wrap_v", 32'(bus5.sel_v), 32'd1);
      check("t6n5_wrap", 32'(bus5.sel), 32'd0);
      check("t6n5_wrap_gnt", 32'(bus5.gnt), 32'h1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
